seq_detector_param: RTL and testbench

Parameterised Moore-style serial sequence detector, the successor to the fixed 5-bit (11011) non-overlapping detector. It adds configurable pattern length, a runtime-loadable pattern, per-cycle overlap/non-overlap mode, an input-valid qualifier and a saturating match counter. It sits on a serial bit stream and flags each completed pattern occurrence with a one-cycle registered pulse.

---
 rtl/seq_detector_param.sv | 73 +++++++
 tb/tb_seq_detector_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised Moore serial sequence detector with a runtime-loadable pattern
// Compares the last PATTERN_LEN valid bits against pat_q; supports optional overlap and a saturating match counter.
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b11011,
  parameter int                     CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in,
  input  logic                   overlap,
  input  logic                   pat_load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  input  logic                   cnt_clr,
  output logic                   out,
  output logic [CNT_W-1:0]       match_count
);

  localparam int            FW        = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] r_pat;
  logic [PATTERN_LEN-1:0] r_hist;
  logic [FW-1:0]          r_fill;
  logic                   r_out;
  logic [CNT_W-1:0]       r_cnt;

  logic [PATTERN_LEN-1:0] w_hist_n;
  logic [FW-1:0]          w_fill_n;
  logic                   w_match;

  // Newest bit enters the LSB, so pat_q[N-1] lines up with the oldest bit of the window.
  always_comb begin
    w_hist_n = {r_hist[PATTERN_LEN-2:0], in};
    w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
    w_match  = in_valid && !pat_load && (w_hist_n == r_pat) && (w_fill_n == FILL_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (pat_load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
        r_out  <= 1'b0;
      end else if (in_valid) begin
        r_hist <= w_hist_n;
        r_out  <= w_match;
        r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
      end else begin
        r_out  <= 1'b0;
      end

      // Clear beats a coincident match; counting stops at all-ones rather than wrapping.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out         = r_out;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
// Drives two instances (CNT_W=8 and CNT_W=2) with shared stimulus and checks every cycle against a queued model.
module tb_seq_detector_param;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         overlap = 1'b0;
  logic         pat_load = 1'b0;
  logic [N-1:0] pat_in = '0;
  logic         cnt_clr = 1'b0;
  logic         out8, out2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(N), .PATTERN(5'b11011), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out8), .match_count(cnt8)
  );

  seq_detector_param #(.PATTERN_LEN(N), .PATTERN(5'b11011), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .out(out2), .match_count(cnt2)
  );

  typedef struct {
    logic       o;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic last_out = 1'b0;

  // Reference model: the bits received since the last segment restart, trimmed to N.
  logic [N-1:0] m_pat = 5'b11011;
  bit           m_seg[$];
  logic [7:0]   m_cnt8 = '0;
  logic [1:0]   m_cnt2 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit seg_match();
    if (m_seg.size() != N) return 1'b0;
    for (int i = 0; i < N; i++)
      if (m_seg[i] != m_pat[N-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pat = 5'b11011;
    m_seg.delete();
    m_cnt8 = '0;
    m_cnt2 = '0;
  endtask

  task automatic step(input bit v, input bit b, input bit ov,
                      input bit ld = 1'b0, input logic [N-1:0] pi = '0, input bit clr = 1'b0);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in_valid = v; in_bit = b; overlap = ov; pat_load = ld; pat_in = pi; cnt_clr = clr;
    e.o = 1'b0;
    if (ld) begin
      m_pat = pi;
      m_seg.delete();
    end else if (v) begin
      m_seg.push_back(b);
      if (m_seg.size() > N) void'(m_seg.pop_front());
      e.o = seg_match();
      if (e.o && !ov) m_seg.delete();
    end
    if (clr) begin
      m_cnt8 = '0;
      m_cnt2 = '0;
    end else if (e.o) begin
      if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
      if (m_cnt2 != 2'h3) m_cnt2 = m_cnt2 + 2'd1;
    end
    e.c8 = m_cnt8;
    e.c2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("out8", {31'd0, out8}, {31'd0, got.o});
      check("out2", {31'd0, out2}, {31'd0, got.o});
      check("cnt8", {24'd0, cnt8}, {24'd0, got.c8});
      check("cnt2", {30'd0, cnt2}, {30'd0, got.c2});
    end
    last_out = out8;
    if (out8) pulses++;
  endtask

  task automatic feed(input logic [31:0] bits, input int len, input bit ov, input int stalls = 0);
    for (int i = len - 1; i >= 0; i--) begin
      step(1'b1, bits[i], ov);
      for (int s = 0; s < stalls; s++) begin
        step(1'b0, 1'b1, ov);
        check("stall_out", {31'd0, last_out}, 32'd0);
      end
    end
  endtask

  task automatic restart(input logic [N-1:0] p);
    step(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1);
    pulses = 0;
  endtask

  initial begin
    // 1. reset and first detection
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_out", {31'd0, out8}, 32'd0);
    check("rst_cnt8", {24'd0, cnt8}, 32'd0);
    check("rst_cnt2", {30'd0, cnt2}, 32'd0);
    pulses = 0;
    feed(32'b11011, 5, 1'b0);
    check("s1_pulses", pulses, 1);
    check("s1_cnt", {24'd0, cnt8}, 32'd1);

    // 2. overlap vs non-overlap
    restart(5'b11011);
    feed(32'b11011011, 8, 1'b0);
    check("s2_nov_pulses", pulses, 1);
    check("s2_nov_cnt", {24'd0, cnt8}, 32'd1);
    restart(5'b11011);
    feed(32'b11011011, 8, 1'b1);
    check("s2_ov_pulses", pulses, 2);
    check("s2_ov_cnt", {24'd0, cnt8}, 32'd2);

    // 3. stalls between every bit
    restart(5'b11011);
    feed(32'b11011011, 8, 1'b1, 2);
    check("s3_pulses", pulses, 2);
    check("s3_cnt", {24'd0, cnt8}, 32'd2);

    // 4. runtime pattern load; the bit presented with pat_load is dropped
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b10101, 1'b1);
    check("s4_load_out", {31'd0, last_out}, 32'd0);
    pulses = 0;
    feed(32'b1010101, 7, 1'b1);
    check("s4_ov_pulses", pulses, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'b10101, 1'b1);
    pulses = 0;
    feed(32'b1010101, 7, 1'b0);
    check("s4_nov_pulses", pulses, 1);

    // 5. counter saturation on the CNT_W=2 instance, then clear against a match
    restart(5'b11011);
    feed(32'b11011, 5, 1'b1);
    for (int k = 0; k < 4; k++) feed(32'b011, 3, 1'b1);
    check("s5_pulses", pulses, 5);
    check("s5_sat2", {30'd0, cnt2}, 32'd3);
    check("s5_cnt8", {24'd0, cnt8}, 32'd5);
    feed(32'b01, 2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("s5_clr_out", {31'd0, out8}, 32'd1);
    check("s5_clr_cnt2", {30'd0, cnt2}, 32'd0);
    check("s5_clr_cnt8", {24'd0, cnt8}, 32'd0);

    // 6. async reset mid-stream with a non-default pattern loaded
    restart(5'b10011);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'b11011, 1'b0);
    feed(32'b1101101, 7, 1'b1);
    check("s6_pre_cnt", {24'd0, cnt8}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'b00111, 1'b0);
    feed(32'b0011, 4, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("s6_async_out", {31'd0, out8}, 32'd0);
    check("s6_async_cnt8", {24'd0, cnt8}, 32'd0);
    check("s6_async_cnt2", {30'd0, cnt2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    feed(32'b1, 1, 1'b1);
    check("s6_no_pulse", pulses, 0);
    feed(32'b11011, 5, 1'b0);
    check("s6_pulses", pulses, 1);
    check("s6_cnt", {24'd0, cnt8}, 32'd1);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
